// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues valid/ready requests to
// instruction memory and buffers in-order responses in a small queue feeding
// decode. A redirect flushes the queue; responses still owed for flushed
// requests are counted in drop_q and discarded on arrival.
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to
// decode when it fills the head entry (saves one cycle of latency).
module fetch_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_STEP = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rst_addr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_instr,
  output logic [XLEN-1:0] dec_pc
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q   [DEPTH];
  logic [XLEN-1:0] epc_d   [DEPTH];
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] instr_d [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;
  ptr_t head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  cnt_t count_q, count_d, pend_q, pend_d, drop_q, drop_d;

  logic [CW:0] occupancy;
  logic        req_fire, rsp_drop, rsp_fill, deq, bypass_hit;

  // Request side: drop_q reserves slots so late flushed responses never overrun.
  assign occupancy      = {1'b0, count_q} + {1'b0, drop_q};
  assign imem_req_valid = rst_n & ~redirect_valid & (occupancy < DepthW);
  assign imem_req_addr  = rst_n ? pc_q : rst_addr;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Responses for flushed requests are consumed before any fill.
  assign rsp_drop = imem_rsp_valid & (drop_q != '0);
  assign rsp_fill = imem_rsp_valid & (drop_q == '0) & (pend_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = rsp_fill & (fill_q == head_q) & (count_q != '0);
`else
  assign bypass_hit = 1'b0;
`endif

  assign dec_valid = (count_q != '0) & (filled_q[head_q] | bypass_hit);
  assign dec_instr = bypass_hit ? imem_rsp_data : instr_q[head_q];
  assign dec_pc    = epc_q[head_q];
  assign deq       = dec_valid & dec_ready;

  // Next-state: allocate at tail, fill oldest unfilled, free head; redirect wins.
  always_comb begin
    pc_d     = pc_q;
    epc_d    = epc_q;
    instr_d  = instr_q;
    filled_d = filled_q;
    head_d   = head_q;
    tail_d   = tail_q;
    fill_d   = fill_q;
    count_d  = count_q + cnt_t'(req_fire) - cnt_t'(deq);
    pend_d   = pend_q + cnt_t'(req_fire) - cnt_t'(rsp_fill);
    drop_d   = drop_q - cnt_t'(rsp_drop);

    if (req_fire) begin
      epc_d[tail_q]    = pc_q;
      filled_d[tail_q] = 1'b0;
      tail_d           = tail_q + 1'b1;
      pc_d             = pc_q + XLEN'(PC_STEP);
    end
    if (rsp_fill) begin
      instr_d[fill_q]  = imem_rsp_data;
      filled_d[fill_q] = 1'b1;
      fill_d           = fill_q + 1'b1;
    end
    // Cleared after the fill so a bypassed head never lingers as filled.
    if (deq) begin
      filled_d[head_q] = 1'b0;
      head_d           = head_q + 1'b1;
    end

    if (redirect_valid) begin
      pc_d     = redirect_addr;
      filled_d = '0;
      head_d   = '0;
      tail_d   = '0;
      fill_d   = '0;
      count_d  = '0;
      pend_d   = '0;
      // Everything still pending becomes owed-and-discarded, minus a response
      // that lands this very cycle.
      drop_d   = drop_q - cnt_t'(rsp_drop) + pend_q - cnt_t'(rsp_fill);
    end
  end

  // State registers; reset loads rst_addr into the PC and empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= rst_addr;
      filled_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      fill_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      drop_q   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        epc_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      filled_q <= filled_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      fill_q   <= fill_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      epc_q    <= epc_d;
      instr_q  <= instr_d;
    end
  end

  // A response with nothing owed is a memory protocol error; it is ignored above.
  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> ((drop_q != '0) || (pend_q != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory model with configurable latency
// answers requests in order, tests push expected decode PCs into a queue and
// a monitor pops and compares on every decode handshake.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rst_addr = 32'h1000;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b1;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

`ifdef FETCH_BYPASS_EN
  localparam int DecLat = 2;
`else
  localparam int DecLat = 3;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  mreq_t       mq[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          dec_cyc[$];
  logic [31:0] sb[$];

  fetch_unit #(
    .XLEN(32),
    .DEPTH(4),
    .PC_STEP(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rst_addr      (rst_addr),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: logs accepted requests, answers each exactly lat cycles later.
  task automatic mem_model();
    mreq_t r;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        cyc = 1;
      end else begin
        if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
        if (imem_req_valid && imem_req_ready) begin
          r.addr = imem_req_addr;
          r.due  = cyc + lat;
          mq.push_back(r);
          req_log.push_back(imem_req_addr);
          req_cyc.push_back(cyc);
        end
        cyc++;
      end
      #1;
      if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mq[0].addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  endtask

  // Monitor: every decode handshake must match the head of the scoreboard.
  task automatic monitor();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && dec_valid && dec_ready) begin
        dec_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dec_unexpected: got pc %h expected no delivery", dec_pc);
        end else begin
          e = sb.pop_front();
          check("dec_pc", dec_pc, e);
          check("dec_instr", dec_instr, instr_of(e));
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reset, check reset-state outputs, release so the current cycle is cycle 1.
  task automatic do_reset(input logic [31:0] addr);
    rst_n          = 1'b0;
    rst_addr       = addr;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, addr);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_dec_instr", dec_instr, 32'd0);
    check("rst_dec_pc", dec_pc, 32'd0);
    @(posedge clk);
    #2;
    req_log.delete();
    req_cyc.delete();
    dec_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic expect_drained(input string name);
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    fork
      mem_model();
      monitor();
    join_none

    // Sequential fetch, L=1, decode always ready.
    do_reset(32'h1000);
    lat = 1;
    for (int i = 0; i < 3; i++) sb.push_back(32'h1000 + 32'(4 * i));
    imem_req_ready = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    step(5);
    check("t1_req_count", 32'(req_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < req_log.size(); i++) begin
      check("t1_req_addr", req_log[i], 32'h1000 + 32'(4 * i));
      check("t1_req_cyc", 32'(req_cyc[i]), 32'(i + 1));
    end
    check("t1_dec_count", 32'(dec_cyc.size()), 32'd3);
    if (dec_cyc.size() == 3) begin
      check("t1_first_dec_cyc", 32'(dec_cyc[0]), 32'(DecLat));
      check("t1_last_dec_cyc", 32'(dec_cyc[2]), 32'(DecLat + 2));
    end
    expect_drained("t1_drained");

    // Decode stall fills the queue, then drains in order.
    do_reset(32'h1000);
    lat = 1;
    dec_ready = 1'b0;
    imem_req_ready = 1'b1;
    step(10);
    check("t2_req_count_full", 32'(req_log.size()), 32'd4);
    check("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
    for (int i = 0; i < 4; i++) sb.push_back(32'h1000 + 32'(4 * i));
    imem_req_ready = 1'b0;
    dec_ready = 1'b1;
    step(1);
    check("t2_req_valid_release", 32'(imem_req_valid), 32'd1);
    step(5);
    expect_drained("t2_drained");
    check("t2_resume_addr", imem_req_addr, 32'h1010);
    sb.push_back(32'h1010);
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    step(4);
    check("t2_req_count", 32'(req_log.size()), 32'd5);
    if (req_log.size() == 5) check("t2_req_resume", req_log[4], 32'h1010);
    expect_drained("t2_drained_resume");

    // L=3, three outstanding, redirect to 0x2000.
    do_reset(32'h1000);
    lat = 3;
    imem_req_ready = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h2000;
    dec_ready      = 1'b0;
    step(1);
    redirect_valid = 1'b0;
    dec_ready      = 1'b1;
    check("t3_drop", 32'(dut.drop_q), 32'd2);
    check("t3_redirect_addr", imem_req_addr, 32'h2000);
    sb.push_back(32'h2000);
    sb.push_back(32'h2004);
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    step(6);
    check("t3_req_count", 32'(req_log.size()), 32'd5);
    if (req_log.size() == 5) begin
      check("t3_req_a", req_log[3], 32'h2000);
      check("t3_req_b", req_log[4], 32'h2004);
    end
    expect_drained("t3_drained");

    // Redirect coincident with a response and a decode handshake.
    do_reset(32'h1000);
    lat = 2;
    sb.push_back(32'h1000);
`ifdef FETCH_BYPASS_EN
    sb.push_back(32'h1004);
`endif
    imem_req_ready = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h3000;
    step(1);
    redirect_valid = 1'b0;
    check("t4_drop_pend_minus_1", 32'(dut.drop_q), 32'd1);
    expect_drained("t4_handshake_done");
    sb.push_back(32'h3000);
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    check("t4_drop_cleared", 32'(dut.drop_q), 32'd0);
    step(5);
    check("t4_req_count", 32'(req_log.size()), 32'd4);
    if (req_log.size() == 4) check("t4_req_redirect", req_log[3], 32'h3000);
    expect_drained("t4_drained");

    // PC wraps past the top of the address space.
    do_reset(32'hFFFF_FFF8);
    lat = 1;
    sb.push_back(32'hFFFF_FFF8);
    sb.push_back(32'hFFFF_FFFC);
    sb.push_back(32'h0000_0000);
    imem_req_ready = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    step(5);
    check("t5_req_count", 32'(req_log.size()), 32'd3);
    if (req_log.size() == 3) begin
      check("t5_req_fff8", req_log[0], 32'hFFFF_FFF8);
      check("t5_req_fffc", req_log[1], 32'hFFFF_FFFC);
      check("t5_req_wrap", req_log[2], 32'h0000_0000);
    end
    expect_drained("t5_drained");

    // Mid-stream reset with the queue half full.
    do_reset(32'h1000);
    lat = 1;
    dec_ready = 1'b0;
    imem_req_ready = 1'b1;
    step(2);
    imem_req_ready = 1'b0;
    step(1);
    check("t6_queue_holds", 32'(dec_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_dec_valid_rst", 32'(dec_valid), 32'd0);
    check("t6_req_valid_rst", 32'(imem_req_valid), 32'd0);
    rst_addr = 32'h5000;
    #1;
    check("t6_req_addr_rst", imem_req_addr, 32'h5000);
    do_reset(32'h5000);
    lat = 1;
    sb.push_back(32'h5000);
    imem_req_ready = 1'b1;
    step(1);
    imem_req_ready = 1'b0;
    step(4);
    check("t6_req_count", 32'(req_log.size()), 32'd1);
    if (req_log.size() == 1) check("t6_restart_addr", req_log[0], 32'h5000);
    expect_drained("t6_drained");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
